// File: rtl/spi_byte_master.sv
// spi_byte_master: SPI mode-0 (CPOL=0, CPHA=0) single-byte full-duplex engine.
// Each accepted start shifts one byte out on mosi_o (MSB first) while shifting
// one byte in from miso_i. Chip select is owned by the caller.
//
// Ports:
//   clk_i     system clock, all logic on posedge
//   reset_ni  asynchronous active-low reset
//   start_i   transfer request, only looked at while idle
//   data_i    byte to send, captured when start is accepted
//   data_o    last received byte, updated in the done cycle
//   done_o    one-cycle completion strobe
//   busy_o    high while a transfer is in progress
//   sck_o     SPI clock, idles low
//   mosi_o    SPI data out, changes on SCK falling edge
//   miso_i    SPI data in, sampled on SCK rising edge
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 2  // system clocks per SCK half-period
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       sck_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("spi_byte_master: CLK_DIV must be >= 1");
    end

    localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSckLo = 2'd1;
    localparam logic [1:0] StSckHi = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]      state_q;
    logic [DivW-1:0] div_cnt_q;
    logic [2:0]      bit_cnt_q;
    // Bit 7 of the transmit byte goes straight to mosi_o at start, so only
    // the remaining seven bits need to be held for shifting.
    logic [6:0]      tx_sr_q;
    logic [7:0]      rx_sr_q;
    logic [7:0]      data_q;
    logic            done_q;
    logic            busy_q;
    logic            sck_q;
    logic            mosi_q;

    logic div_last;
    assign div_last = (div_cnt_q == DivLast);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        tx_sr_q   <= data_i[6:0];
                        mosi_q    <= data_i[7];
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StSckLo;
                    end
                end
                StSckLo: begin
                    if (div_last) begin
                        // Sample at the moment SCK rises.
                        rx_sr_q   <= {rx_sr_q[6:0], miso_i};
                        sck_q     <= 1'b1;
                        div_cnt_q <= '0;
                        state_q   <= StSckHi;
                    end else begin
                        div_cnt_q <= div_cnt_q + DivW'(1);
                    end
                end
                StSckHi: begin
                    if (div_last) begin
                        sck_q     <= 1'b0;
                        div_cnt_q <= '0;
                        if (bit_cnt_q != 3'd7) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_sr_q   <= {tx_sr_q[5:0], 1'b0};
                            mosi_q    <= tx_sr_q[6];
                            state_q   <= StSckLo;
                        end else begin
                            data_q  <= rx_sr_q;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            mosi_q  <= 1'b0;
                            state_q <= StDone;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DivW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_o = data_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: one instance with CLK_DIV=2, one with CLK_DIV=1.
`define CHK(TAG, OBS, EXP) begin n_cmp++; assert ((OBS) === (EXP)) else begin n_err++; $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); end end

module tb_spi_byte_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    // Instance 0: CLK_DIV = 2
    logic       start0, done0, busy0, sck0, mosi0, miso0;
    logic [7:0] data0, rdata0;
    // Instance 1: CLK_DIV = 1
    logic       start1, done1, busy1, sck1, mosi1, miso1;
    logic [7:0] data1, rdata1;

    spi_byte_master #(.CLK_DIV(2)) u_dut0 (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start0), .data_i(data0),
        .data_o(rdata0), .done_o(done0), .busy_o(busy0), .sck_o(sck0),
        .mosi_o(mosi0), .miso_i(miso0)
    );

    spi_byte_master #(.CLK_DIV(1)) u_dut1 (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start1), .data_i(data1),
        .data_o(rdata1), .done_o(done1), .busy_o(busy1), .sck_o(sck1),
        .mosi_o(mosi1), .miso_i(miso1)
    );

    // Flash models: record MOSI on each SCK rise, present slave byte MSB first
    // relative to the rise count at transfer start.
    int         rises0 = 0, rises1 = 0;
    logic [7:0] hist0 = 8'h00, hist1 = 8'h00;
    int         base0, base1;
    logic [7:0] sl0, sl1;

    always @(posedge sck0) begin
        hist0  <= {hist0[6:0], mosi0};
        rises0 <= rises0 + 1;
    end

    always @(posedge sck1) begin
        hist1  <= {hist1[6:0], mosi1};
        rises1 <= rises1 + 1;
    end

    always_comb begin
        miso0 = 1'b0;
        if (rises0 >= base0 && rises0 - base0 < 8) miso0 = sl0[3'(7 - (rises0 - base0))];
    end

    always_comb begin
        miso1 = 1'b0;
        if (rises1 >= base1 && rises1 - base1 < 8) miso1 = sl1[3'(7 - (rises1 - base1))];
    end

    // One transfer on instance 0 observed over a 40-cycle window. With hold set,
    // start stays high until done is seen and data_i is changed mid-transfer.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input bit hold,
                        output int dn, output int dpos, output int bsy,
                        output logic [7:0] rx);
        base0 = rises0;
        sl0   = sl;
        dn    = 0;
        dpos  = -1;
        bsy   = 0;
        rx    = 8'hxx;
        @(negedge clk);
        start0 = 1'b1;
        data0  = tx;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                `CHK("busy_at_t1", busy0, 1'b1)
                `CHK("mosi_at_t1", mosi0, tx[7])
            end
            if (hold && n == 10) data0 = 8'hFF;
            if (busy0) bsy++;
            if (done0) begin
                dn++;
                if (dpos < 0) dpos = n;
                rx = rdata0;
            end
            if (!hold || done0) start0 = 1'b0;
        end
    endtask

    int         dn, dpos, bsy;
    logic [7:0] rx;
    int         dtimes[3];
    int         rstart, cyc;
    bit         pending, saw_done;
    int         sck_bad;

    initial begin
        reset_n = 1'b0;
        start0 = 1'b0; data0 = 8'h00; start1 = 1'b0; data1 = 8'h00;
        sl0 = 8'h00; sl1 = 8'h00; base0 = 0; base1 = 0;
        #23;
        `CHK("reset_outs0", {rdata0, done0, busy0, sck0, mosi0}, 12'h000)
        `CHK("reset_outs1", {rdata1, done1, busy1, sck1, mosi1}, 12'h000)
        @(negedge clk);
        reset_n = 1'b1;

        // Basic transfer: send 0x03, flash returns 0xA5.
        xfer(8'h03, 8'hA5, 1'b0, dn, dpos, bsy, rx);
        `CHK("t1_done_cnt", dn, 1)
        `CHK("t1_done_pos", dpos, 32)
        `CHK("t1_busy_cyc", bsy, 32)
        `CHK("t1_rx", rx, 8'hA5)
        `CHK("t1_mosi", hist0, 8'h03)
        `CHK("t1_rises", rises0 - base0, 8)
        `CHK("t1_data_held", rdata0, 8'hA5)
        `CHK("t1_sck_idle", sck0, 1'b0)

        // Back-to-back: three 0x00 bytes, each start in the cycle after done.
        rstart  = rises0;
        base0   = rises0;
        sl0     = 8'h00;
        pending = 1'b0;
        dn      = 0;
        @(negedge clk);
        start0 = 1'b1;
        data0  = 8'h00;
        for (int n = 0; n < 120; n++) begin
            @(negedge clk);
            start0  = pending;
            pending = 1'b0;
            if (done0) begin
                if (dn < 3) dtimes[dn] = n;
                dn++;
                if (dn < 3) pending = 1'b1;
            end
        end
        `CHK("b2b_done_cnt", dn, 3)
        `CHK("b2b_gap1", dtimes[1] - dtimes[0], 34)
        `CHK("b2b_gap2", dtimes[2] - dtimes[1], 34)
        `CHK("b2b_rises", rises0 - rstart, 24)
        `CHK("b2b_rx", rdata0, 8'h00)

        // start held high through the transfer, data_i changed to 0xFF.
        xfer(8'h3C, 8'h5A, 1'b1, dn, dpos, bsy, rx);
        `CHK("hold_done_cnt", dn, 1)
        `CHK("hold_mosi", hist0, 8'h3C)
        `CHK("hold_rx", rx, 8'h5A)
        `CHK("hold_busy_cyc", bsy, 32)
        `CHK("hold_not_queued", busy0, 1'b0)

        // Reset asserted after the 4th SCK rise.
        base0 = rises0;
        sl0   = 8'h3C;
        @(negedge clk);
        start0 = 1'b1;
        data0  = 8'h96;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 100 && (rises0 - base0) < 4; k++) @(negedge clk);
        `CHK("rst_reach_rise4", rises0 - base0, 4)
        #2;
        reset_n = 1'b0;
        #1;
        `CHK("rst_async_outs", {rdata0, done0, busy0, sck0, mosi0}, 12'h000)
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) reset_n = 1'b1;
            if (done0) saw_done = 1'b1;
        end
        `CHK("rst_no_done", saw_done, 1'b0)
        `CHK("rst_idle_after", {busy0, sck0}, 2'b00)
        xfer(8'h81, 8'h7E, 1'b0, dn, dpos, bsy, rx);
        `CHK("post_rst_done_pos", dpos, 32)
        `CHK("post_rst_rx", rx, 8'h7E)
        `CHK("post_rst_mosi", hist0, 8'h81)

        // CLK_DIV=1: send 0x5A, flash returns 0xC3.
        base1   = rises1;
        sl1     = 8'hC3;
        sck_bad = 0;
        dn      = 0;
        dpos    = -1;
        @(negedge clk);
        start1 = 1'b1;
        data1  = 8'h5A;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (n < 16 && sck1 !== n[0]) sck_bad++;
            if (done1) begin
                dn++;
                dpos = n;
                rx   = rdata1;
            end
        end
        `CHK("div1_sck_toggle", sck_bad, 0)
        `CHK("div1_done_cnt", dn, 1)
        `CHK("div1_done_pos", dpos, 16)
        `CHK("div1_rx", rx, 8'hC3)
        `CHK("div1_mosi", hist1, 8'h5A)
        `CHK("div1_rises", rises1 - base1, 8)
        `CHK("div1_idle", {busy1, sck1, mosi1}, 3'b000)

        cyc = n_cmp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cyc, n_err);
        $finish;
    end

endmodule
